rs232_avm_slave: RTL and testbench

//  Avalon-MM slave emulating the RS232 UART register map polled by the RSA256 host wrapper.
//  - Accepts a byte stream (key n, key e, ciphertext) on the rx port.
//  - Returns it byte-by-byte through the RX data register.
//  - Collects bytes the master writes to the TX register and emits them on the tx stream.
//  - Used as the bus-side peer in simulation and as the FPGA bridge to a byte-level UART core.

---
 rtl/rs232_avm_slave_if.sv | 18 +
 rtl/rs232_avm_slave.sv | 140 ++++++++++++++
 tb/tb_rs232_avm_slave.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_avm_slave_if.sv
// Avalon-MM bus signals between the host master and the RS232 register-map slave.
interface rs232_avm_slave_if;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );
  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/rs232_avm_slave.sv
// UART register-map emulator: RX byte stream polled through a data register,
// TX register writes queued and replayed as a byte stream.
module rs232_avm_slave #(
  parameter int RX_DEPTH    = 8,
  parameter int TX_DEPTH    = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              avm_clk,
  input  logic              avm_rst,
  rs232_avm_slave_if.slave  avs,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [4:0] A_RX = 5'd0, A_TX = 5'd4, A_ST = 5'd8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e      state_q, state_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic        op_rd_q, op_rd_d;
  logic [4:0]  addr_q, addr_d;
  logic        err_q, err_d;
  logic        req, ack;

  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_AW-1:0] rx_wptr_q, rx_rptr_q;
  logic [RX_AW:0]   rx_cnt_q;
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [TX_AW-1:0] tx_wptr_q, tx_rptr_q;
  logic [TX_AW:0]   tx_cnt_q;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, tx_push, tx_pop, tx_wr, rx_rd, st_rd;

  assign req = avs.avs_read | avs.avs_write;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      op_rd_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      op_rd_q <= op_rd_d;
      addr_q  <= addr_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    op_rd_d = op_rd_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: if (req) begin
        op_rd_d = avs.avs_read;  // read wins when both are raised
        addr_d  = avs.avs_address;
        wcnt_d  = 3'(WAIT_CYCLES);
        state_d = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
      end
      S_WAIT: if (!req) begin
        state_d = S_IDLE;
      end else begin
        wcnt_d = wcnt_q - 3'd1;
        if (wcnt_q == 3'd1) state_d = S_ACK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ack              = (state_q == S_ACK) && !avm_rst;
    avs.avs_waitrequest = !ack;
    avs.avs_readdata = '0;
    if (ack && op_rd_q) begin
      unique case (addr_q)
        A_RX:    if (!rx_empty) avs.avs_readdata = {24'b0, rx_mem_q[rx_rptr_q]};
        A_ST:    avs.avs_readdata = {24'b0, !rx_empty, !tx_full, err_q, 5'b0};
        default: avs.avs_readdata = '0;
      endcase
    end
  end

  // ---------------- side effects ----------------
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == (RX_AW+1)'(RX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == (TX_AW+1)'(TX_DEPTH));

  assign rx_ready = !avm_rst && !rx_full;
  assign tx_valid = !avm_rst && !tx_empty;
  assign tx_data  = tx_mem_q[tx_rptr_q];

  assign rx_rd   = ack && op_rd_q && (addr_q == A_RX);
  assign st_rd   = ack && op_rd_q && (addr_q == A_ST);
  assign tx_wr   = ack && !op_rd_q && (addr_q == A_TX);
  assign rx_push = rx_valid && rx_ready;
  assign rx_pop  = rx_rd && !rx_empty;
  assign tx_pop  = tx_valid && tx_ready;
  // A full TX still accepts the byte when the stream drains one the same cycle
  assign tx_push = tx_wr && (!tx_full || tx_pop);

  assign err_d = (err_q && !st_rd) || (rx_rd && rx_empty) || (tx_wr && !tx_push);

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      err_q     <= 1'b0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      err_q <= err_d;
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      rx_cnt_q <= rx_cnt_q + {{RX_AW{1'b0}}, rx_push} - {{RX_AW{1'b0}}, rx_pop};
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + {{TX_AW{1'b0}}, tx_push} - {{TX_AW{1'b0}}, tx_pop};
    end
  end

  always_ff @(posedge avm_clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
    if (tx_push) tx_mem_q[tx_wptr_q] <= avs.avs_writedata[7:0];
  end
endmodule

// File: tb/tb_rs232_avm_slave.sv
// Self-checking bench for rs232_avm_slave: directed scenarios plus a randomized
// mix of stream and bus traffic checked against a queue-based register model.
module tb_rs232_avm_slave;
  localparam int RXD = 8, TXD = 4, W = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs232_avm_slave_if avs ();
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_ready, tx_valid, tx_ready;

  rs232_avm_slave #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .WAIT_CYCLES(W)) dut (
    .avm_clk(clk), .avm_rst(rst), .avs(avs),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register model: byte queues plus the sticky error flag
  logic [7:0] rxq[$], txq[$];
  bit err_m = 1'b0;

  function automatic logic [31:0] model(input bit rd, input logic [4:0] a, input logic [7:0] wd);
    logic [31:0] r = '0;
    if (rd) begin
      if (a == 5'd0) begin
        if (rxq.size() > 0) r = {24'b0, rxq.pop_front()};
        else err_m = 1'b1;
      end else if (a == 5'd8) begin
        r = {24'b0, rxq.size() > 0, txq.size() < TXD, err_m, 5'b0};
        err_m = 1'b0;
      end
    end else if (a == 5'd4) begin
      if (txq.size() < TXD) txq.push_back(wd);
      else err_m = 1'b1;
    end
    return r;
  endfunction

  // One bus transaction; caller is just after a posedge, returns just after the commit edge
  task automatic bus(input bit rd, input logic [4:0] a, input logic [7:0] wd,
                     output logic [31:0] rdata, output int lat, output int ack_cyc);
    avs.avs_read      = rd;
    avs.avs_write     = !rd;
    avs.avs_address   = a;
    avs.avs_writedata = {24'($urandom), wd};
    lat = -1; rdata = '0; ack_cyc = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!avs.avs_waitrequest) begin
        rdata = avs.avs_readdata; lat = n - 1; ack_cyc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    avs.avs_read = 1'b0; avs.avs_write = 1'b0;
  endtask

  task automatic push_rx(input logic [7:0] b);
    bit ok = 1'b0;
    rx_valid = 1'b1; rx_data = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rx_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL push_rx timeout byte=%h", b); end
    else rxq.push_back(b);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h11; tx_ready = 1'b0;
    avs.avs_read = 1'b0; avs.avs_write = 1'b0; avs.avs_address = '0; avs.avs_writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (avs.avs_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_waitreq got=%b exp=1", avs.avs_waitrequest); end
    n_chk++; if (avs.avs_readdata !== 32'h0) begin n_fail++; $display("FAIL rst_readdata got=%h exp=0", avs.avs_readdata); end
    n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
    n_chk++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rx_ready got=%b exp=0", rx_ready); end
    @(posedge clk); #1;
    rst = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_rx_ready got=%b exp=1", rx_ready); end
    n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_tx_valid got=%b exp=0", tx_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_status();
    logic [31:0] rd; int lat, ac;
    void'(model(1'b1, 5'd8, 8'h0));
    bus(1'b1, 5'd8, 8'h0, rd, lat, ac);
    n_chk++; if (lat !== W + 1) begin n_fail++; $display("FAIL status_latency got=%0d exp=%0d", lat, W + 1); end
    n_chk++; if (rd !== 32'h40) begin n_fail++; $display("FAIL status_idle got=%h exp=40", rd); end
  endtask

  task automatic test_rx_read();
    logic [31:0] rd, exp[4]; logic [4:0] ad[4]; int lat, ac;
    exp = '{32'hC0, 32'hA5, 32'h3C, 32'h40};
    ad  = '{5'd8, 5'd0, 5'd0, 5'd8};
    push_rx(8'hA5); push_rx(8'h3C);
    for (int i = 0; i < 4; i++) begin
      void'(model(1'b1, ad[i], 8'h0));
      bus(1'b1, ad[i], 8'h0, rd, lat, ac);
      n_chk++; if (rd !== exp[i]) begin n_fail++; $display("FAIL rx_read[%0d] got=%h exp=%h", i, rd, exp[i]); end
    end
  endtask

  task automatic test_rx_full();
    logic [31:0] rd, e; int lat, ac;
    for (int i = 0; i < RXD; i++) push_rx(8'(8'h10 + i));
    @(negedge clk);
    n_chk++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_full_ready got=%b exp=0", rx_ready); end
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 8'h99;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_held_ready got=%b exp=0", rx_ready); end
    @(posedge clk); #1;
    e = model(1'b1, 5'd0, 8'h0);
    bus(1'b1, 5'd0, 8'h0, rd, lat, ac);
    n_chk++; if (rd !== 32'h10) begin n_fail++; $display("FAIL rx_full_pop got=%h exp=10", rd); end
    @(negedge clk);
    n_chk++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ninth_ready got=%b exp=1", rx_ready); end
    @(posedge clk); #1;
    rx_valid = 1'b0; rxq.push_back(8'h99);
    for (int i = 0; i < RXD + 1; i++) begin
      e = model(1'b1, 5'd0, 8'h0);
      bus(1'b1, 5'd0, 8'h0, rd, lat, ac);
      n_chk++; if (rd !== e) begin n_fail++; $display("FAIL rx_drain[%0d] got=%h exp=%h", i, rd, e); end
    end
    e = model(1'b1, 5'd8, 8'h0);
    bus(1'b1, 5'd8, 8'h0, rd, lat, ac);
    n_chk++; if (rd !== 32'h60) begin n_fail++; $display("FAIL rx_underflow_status got=%h exp=60", rd); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] rd; int lat, ac;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      void'(model(1'b0, 5'd4, 8'(8'hB0 + i)));
      bus(1'b0, 5'd4, 8'(8'hB0 + i), rd, lat, ac);
    end
    void'(model(1'b1, 5'd8, 8'h0));
    bus(1'b1, 5'd8, 8'h0, rd, lat, ac);
    n_chk++; if (rd !== 32'h20) begin n_fail++; $display("FAIL tx_overflow_status got=%h exp=20", rd); end
    void'(model(1'b1, 5'd8, 8'h0));
    bus(1'b1, 5'd8, 8'h0, rd, lat, ac);
    n_chk++; if (rd !== 32'h00) begin n_fail++; $display("FAIL err_cleared got=%h exp=00", rd); end
    tx_ready = 1'b1;
    for (int i = 0; i < TXD; i++) begin
      @(negedge clk);
      n_chk++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'hB0 + i)) begin
        n_fail++; $display("FAIL tx_drain[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, 8'(8'hB0 + i));
      end
      @(posedge clk); #1;
      void'(txq.pop_front());
    end
    tx_ready = 1'b0;
    @(negedge clk);
    n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_dropped_fifth got=%b exp=0", tx_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_tx_stream();
    logic [31:0] rd; int lat, ac;
    tx_ready = 1'b1;
    bus(1'b0, 5'd4, 8'h7E, rd, lat, ac);
    @(negedge clk);
    n_chk++; if (tx_valid !== 1'b1 || tx_data !== 8'h7E) begin
      n_fail++; $display("FAIL tx_stream_emit got=%b/%h exp=1/7e", tx_valid, tx_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_stream_pop got=%b exp=0", tx_valid); end
    @(posedge clk); #1;
    tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int lat, ac, prev;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      void'(model(1'b1, 5'd8, 8'h0));
      bus(1'b1, 5'd8, 8'h0, rd, lat, ac);
      if (prev >= 0) begin
        n_chk++; if (ac - prev !== W + 2) begin n_fail++; $display("FAIL b2b_period got=%0d exp=%0d", ac - prev, W + 2); end
      end
      prev = ac;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat, ac; bit acked = 1'b0;
    push_rx(8'h5A);
    avs.avs_read = 1'b1; avs.avs_address = 5'd0;
    @(negedge clk); if (!avs.avs_waitrequest) acked = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); if (!avs.avs_waitrequest) acked = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; avs.avs_read = 1'b0;
    @(negedge clk); if (!avs.avs_waitrequest) acked = 1'b1;
    n_chk++; if (acked !== 1'b0) begin n_fail++; $display("FAIL reset_mid_ack got=%b exp=0", acked); end
    @(posedge clk); #1;
    rxq.delete(); txq.delete(); err_m = 1'b0;
    void'(model(1'b1, 5'd8, 8'h0));
    bus(1'b1, 5'd8, 8'h0, rd, lat, ac);
    n_chk++; if (rd !== 32'h40) begin n_fail++; $display("FAIL reset_mid_status got=%h exp=40", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, e; int lat, ac; bit r; logic [4:0] a; logic [7:0] b;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0: begin
          b = 8'($urandom);
          if (rxq.size() < RXD) push_rx(b);
          else begin
            @(negedge clk);
            n_chk++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rnd_rx_full got=%b exp=0", rx_ready); end
            @(posedge clk); #1;
          end
        end
        1: begin
          tx_ready = 1'b1;
          @(negedge clk);
          n_chk++; if (tx_valid !== (txq.size() != 0) || (txq.size() != 0 && tx_data !== txq[0])) begin
            n_fail++; $display("FAIL rnd_tx_pop got=%b/%h exp_valid=%b", tx_valid, tx_data, txq.size() != 0);
          end
          @(posedge clk); #1;
          tx_ready = 1'b0;
          if (txq.size() != 0) void'(txq.pop_front());
        end
        default: begin
          r = 1'($urandom);
          case ($urandom_range(0, 3))
            0: a = 5'd0;
            1: a = 5'd4;
            2: a = 5'd8;
            default: a = 5'($urandom);
          endcase
          b = 8'($urandom);
          e = model(r, a, b);
          bus(r, a, b, rd, lat, ac);
          n_chk++; if (rd !== e || lat !== W + 1) begin
            n_fail++; $display("FAIL rnd_bus rd=%b a=%0d got=%h lat=%0d exp=%h lat=%0d", r, a, rd, lat, e, W + 1);
          end
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_status();
    test_rx_read();
    test_rx_full();
    test_tx_overflow();
    test_tx_stream();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
